// File: rtl/vec_stream_pkg.sv
// vec_stream_pkg
//   Shared types and default geometry for the vector sample streamer.
//   Default word is 128 bits carrying 16 lanes of 8-bit samples.
package vec_stream_pkg;

    localparam int VEC_DATA_W   = 128;
    localparam int VEC_SAMPLE_W = 8;
    localparam int LANES        = VEC_DATA_W / VEC_SAMPLE_W;
    localparam int LANE_W       = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STREAM,
        DRAIN
    } state_t;

endpackage

// File: rtl/vec_read_port.sv
// vec_read_port
//   Read-only front end to the vector RAM port b. An issue presents the
//   address combinationally in the same cycle, so the RAM samples it on
//   that edge. A valid shift register tracks the read through the RAM
//   latency, and rd_valid rises in the cycle mem_q carries the word.
//
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_flush          drop any in-flight read (abort)
//   i_issue          start a read of i_issue_addr this cycle
//   o_mem_addr       address to the RAM; holds the last issued address
//   i_mem_q          RAM read data
//   o_rd_valid       o_rd_data holds the word of the oldest read
//   o_rd_busy        a read is in flight (includes the o_rd_valid cycle)
module vec_read_port #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 128,
    parameter int READ_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_issue,
    input  logic [ADDR_W-1:0] i_issue_addr,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_q,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_busy
);

    logic                w_issue;
    logic [READ_LAT:0]   w_vld_pipe;
    logic [READ_LAT:1]   r_vld_pipe;
    logic [ADDR_W-1:0]   r_addr;

    // A flushed or reset cycle never starts a read.
    assign w_issue    = i_issue && !i_flush && !i_reset;
    assign w_vld_pipe = {r_vld_pipe, w_issue};

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe <= w_vld_pipe[READ_LAT-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr <= '0;
        end else if (w_issue) begin
            r_addr <= i_issue_addr;
        end
    end

    assign o_mem_addr = w_issue ? i_issue_addr : r_addr;
    assign o_rd_valid = r_vld_pipe[READ_LAT];
    assign o_rd_data  = i_mem_q;
    assign o_rd_busy  = |r_vld_pipe;

endmodule

// File: rtl/vec_sample_streamer.sv
// vec_sample_streamer
//   Drains 128-bit words from the vector RAM (port b, read-only) and
//   emits them as a valid/ready stream of 8-bit samples, lane 0 first.
//   A one-word prefetch buffer keeps a ready sink fed without bubbles
//   across word boundaries.
//
//   clk, reset       clock, synchronous active-high reset
//   start            pulse in IDLE: latch base_addr/num_words, begin
//   abort            stop the transfer, back to IDLE, no done pulse
//   base_addr        first word address
//   num_words        words to stream (0 -> immediate done)
//   busy             transfer in progress
//   done             one-cycle pulse after the last sample
//   mem_addr/mem_q   RAM port b address / read data
//   sample_out       current sample
//   sample_valid     sample_out valid
//   sample_ready     sink accepts when valid && ready
module vec_sample_streamer
    import vec_stream_pkg::*;
#(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = VEC_DATA_W,
    parameter int SAMPLE_W = VEC_SAMPLE_W,
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   num_words,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_q,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    input  logic                sample_ready
);

    localparam int NLANES = DATA_W / SAMPLE_W;
    localparam int LW     = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(NLANES - 1);

    state_t                           r_state;
    logic [ADDR_W-1:0]                r_next_addr;
    logic [ADDR_W-1:0]                r_remain;     // words not yet fetched
    logic [DATA_W-1:0]                r_cur_buf;
    logic [DATA_W-1:0]                r_nxt_buf;
    logic                             r_nxt_valid;
    logic                             r_sample_valid;
    logic                             r_busy;
    logic                             r_done;
    logic [LW-1:0]                    r_lane;

    logic [NLANES-1:0][SAMPLE_W-1:0]  w_lanes;
    logic                             w_abort;
    logic                             w_hs;
    logic                             w_start_go;
    logic                             w_prefetch;
    logic                             w_issue;
    logic [ADDR_W-1:0]                w_issue_addr;
    logic                             w_rd_valid;
    logic                             w_rd_busy;
    logic [DATA_W-1:0]                w_rd_data;

    assign w_abort      = abort && (r_state != IDLE);
    assign w_hs         = r_sample_valid && sample_ready;
    assign w_start_go   = (r_state == IDLE) && start && (num_words != '0);
    // Only one read outstanding into nxt_buf at a time.
    assign w_prefetch   = (r_state == STREAM) && (r_remain != '0) &&
                          !r_nxt_valid && !w_rd_busy;
    assign w_issue      = w_start_go || w_prefetch;
    assign w_issue_addr = (r_state == IDLE) ? base_addr : r_next_addr;

    vec_read_port #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_rd (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_flush      (w_abort),
        .i_issue      (w_issue),
        .i_issue_addr (w_issue_addr),
        .o_mem_addr   (mem_addr),
        .i_mem_q      (mem_q),
        .o_rd_valid   (w_rd_valid),
        .o_rd_data    (w_rd_data),
        .o_rd_busy    (w_rd_busy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_next_addr    <= '0;
            r_remain       <= '0;
            r_cur_buf      <= '0;
            r_nxt_buf      <= '0;
            r_nxt_valid    <= 1'b0;
            r_sample_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_lane         <= '0;
        end else if (w_abort) begin
            // Abort wins over any handshake in the same cycle.
            r_state        <= IDLE;
            r_remain       <= '0;
            r_cur_buf      <= '0;
            r_nxt_buf      <= '0;
            r_nxt_valid    <= 1'b0;
            r_sample_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_lane         <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (num_words == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_next_addr <= base_addr + 1'b1;
                            r_remain    <= num_words - 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (w_rd_valid) begin
                        r_cur_buf      <= w_rd_data;
                        r_lane         <= '0;
                        r_sample_valid <= 1'b1;
                        r_state        <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_prefetch) begin
                        r_next_addr <= r_next_addr + 1'b1;   // wraps mod 2^ADDR_W
                        r_remain    <= r_remain - 1'b1;
                    end
                    if (w_rd_valid) begin
                        r_nxt_buf   <= w_rd_data;
                        r_nxt_valid <= 1'b1;
                    end
                    if (w_hs) begin
                        if (r_lane != LAST_LANE) begin
                            r_lane <= r_lane + 1'b1;
                        end else if (r_nxt_valid) begin
                            // Word boundary with the next word ready: no bubble.
                            r_cur_buf   <= r_nxt_buf;
                            r_lane      <= '0;
                            r_nxt_valid <= 1'b0;
                        end else if ((r_remain != '0) || w_rd_busy) begin
                            // Sink outran the prefetch; wait for it to land.
                            r_sample_valid <= 1'b0;
                        end else begin
                            r_sample_valid <= 1'b0;
                            r_busy         <= 1'b0;
                            r_done         <= 1'b1;
                            r_state        <= DRAIN;
                        end
                    end else if (!r_sample_valid && r_nxt_valid) begin
                        r_cur_buf      <= r_nxt_buf;
                        r_lane         <= '0;
                        r_nxt_valid    <= 1'b0;
                        r_sample_valid <= 1'b1;
                    end
                end
                DRAIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_lanes      = r_cur_buf;
    assign sample_out   = w_lanes[r_lane];
    assign sample_valid = r_sample_valid;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_vec_sample_streamer.sv
module tb_vec_sample_streamer;

    localparam int AW = 15;
    localparam int DW = 128;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] num_words;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_q;
    logic [SW-1:0] sample_out;
    logic          sample_valid;
    logic          sample_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vec_sample_streamer #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .SAMPLE_W (SW),
        .READ_LAT (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .base_addr    (base_addr),
        .num_words    (num_words),
        .busy         (busy),
        .done         (done),
        .mem_addr     (mem_addr),
        .mem_q        (mem_q),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready)
    );

    // Memory contents: lane i of word a. Word 0x10 holds lane i = i.
    function automatic logic [7:0] pat(input int a, input int i);
        int v;
        v = i + a * 16 + (a >> 4) - 1;
        return v[7:0];
    endfunction

    function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int i = 0; i < 16; i++) w[i*8 +: 8] = pat(int'(a), i);
        return w;
    endfunction

    // Registered-output RAM, one cycle read latency.
    always @(posedge clk) mem_q <= word_at(mem_addr);

    function automatic logic ready_for(input int mode, input int c);
        if (mode == 0) return 1'b1;
        return ((c % 4) == 0) || ((c % 4) == 3);   // 1,0,0,1
    endfunction

    // Transfer records filled by run_xfer
    logic [7:0]    samp [0:127];
    logic [AW-1:0] addrs [0:15];
    int n_samp, n_addr, n_done, first_valid, first_done, last_samp_cyc;
    int gap, unstable, abort_cyc, timeout;
    logic busy_seen, valid_seen, valid_after_abort, busy_after_abort;

    task automatic run_xfer(input logic [AW-1:0] base, input logic [AW-1:0] num,
                            input int rmode, input int abort_at, input int max_cyc);
        logic prev_valid, prev_ready;
        logic [7:0] prev_out;
        int total;
        total = int'(num) * 16;
        n_samp = 0; n_addr = 0; n_done = 0; first_valid = -1; first_done = -1;
        last_samp_cyc = -1; gap = 0; unstable = 0; abort_cyc = -1; timeout = 1;
        busy_seen = 0; valid_seen = 0; valid_after_abort = 0; busy_after_abort = 0;
        prev_valid = 0; prev_ready = 0; prev_out = '0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; num_words = num;
        sample_ready = ready_for(rmode, 0);
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if ((n_addr == 0 || mem_addr != addrs[n_addr-1]) && n_addr < 16) begin
                addrs[n_addr] = mem_addr;
                n_addr++;
            end
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
            if (busy) busy_seen = 1;
            if (sample_valid) begin
                valid_seen = 1;
                if (first_valid < 0) first_valid = c;
            end else if (first_valid >= 0 && n_samp < total && abort_cyc < 0) begin
                gap++;
            end
            if (prev_valid && !prev_ready && (!sample_valid || sample_out != prev_out))
                unstable++;
            if (abort_cyc >= 0 && c == abort_cyc + 1) begin
                valid_after_abort = sample_valid;
                busy_after_abort  = busy;
            end
            if (sample_valid && sample_ready && !abort) begin
                if (n_samp < 128) samp[n_samp] = sample_out;
                n_samp++;
                last_samp_cyc = c;
            end
            prev_valid = sample_valid; prev_ready = sample_ready; prev_out = sample_out;
            if (abort_cyc < 0 && done) begin timeout = 0; break; end
            if (abort_cyc >= 0 && c == abort_cyc + 20) begin timeout = 0; break; end
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            if (abort_at >= 0 && abort_cyc < 0 && n_samp == abort_at) begin
                abort = 1'b1;
                abort_cyc = c + 1;
            end
            sample_ready = ready_for(rmode, c + 1);
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; sample_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; sample_ready = 1'b1;
        base_addr = '0; num_words = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", sample_valid); end
        checks++; if (sample_out !== 8'h00) begin failures++; $display("FAIL reset_out got %h exp 00", sample_out); end
        checks++; if (mem_addr !== 15'h0) begin failures++; $display("FAIL reset_addr got %h exp 0000", mem_addr); end
        @(posedge clk); #1; reset = 1'b0;
        // Reset in the middle of a transfer
        @(posedge clk); #1; start = 1'b1; base_addr = 15'h0010; num_words = 15'd2;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (sample_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            begin failures++; $display("FAIL midreset_ctl got v%b b%b d%b exp 000", sample_valid, busy, done); end
        checks++; if (mem_addr !== 15'h0 || sample_out !== 8'h00)
            begin failures++; $display("FAIL midreset_data got a%h s%h exp 0000/00", mem_addr, sample_out); end
        @(posedge clk); #1; reset = 1'b0;
    endtask

    task automatic test_single_word();
        run_xfer(15'h0010, 15'd1, 0, -1, 100);
        checks++; if (timeout !== 0) begin failures++; $display("FAIL single_timeout got %0d exp 0", timeout); end
        checks++; if (n_samp !== 16) begin failures++; $display("FAIL single_count got %0d exp 16", n_samp); end
        for (int k = 0; k < 16 && k < n_samp; k++) begin
            checks++;
            if (samp[k] !== 8'(k)) begin failures++; $display("FAIL single_sample%0d got %h exp %h", k, samp[k], 8'(k)); end
        end
        checks++; if (first_valid !== 2) begin failures++; $display("FAIL single_first_valid got %0d exp 2", first_valid); end
        checks++; if (last_samp_cyc !== 17) begin failures++; $display("FAIL single_last_cyc got %0d exp 17", last_samp_cyc); end
        checks++; if (first_done !== 18) begin failures++; $display("FAIL single_done_cyc got %0d exp 18", first_done); end
        checks++; if (gap !== 0) begin failures++; $display("FAIL single_gap got %0d exp 0", gap); end
    endtask

    task automatic test_back_to_back();
        run_xfer(15'h0020, 15'd3, 0, -1, 200);
        checks++; if (timeout !== 0) begin failures++; $display("FAIL b2b_timeout got %0d exp 0", timeout); end
        checks++; if (n_samp !== 48) begin failures++; $display("FAIL b2b_count got %0d exp 48", n_samp); end
        checks++; if (gap !== 0) begin failures++; $display("FAIL b2b_gap got %0d exp 0", gap); end
        checks++; if (n_addr !== 3 || addrs[0] !== 15'h20 || addrs[1] !== 15'h21 || addrs[2] !== 15'h22)
            begin failures++; $display("FAIL b2b_addrs got n%0d %h %h %h exp 3 0020 0021 0022", n_addr, addrs[0], addrs[1], addrs[2]); end
        for (int k = 0; k < 48 && k < n_samp; k++) begin
            checks++;
            if (samp[k] !== pat(32'h20 + k / 16, k % 16))
                begin failures++; $display("FAIL b2b_sample%0d got %h exp %h", k, samp[k], pat(32'h20 + k / 16, k % 16)); end
        end
        checks++; if (first_done !== last_samp_cyc + 1) begin failures++; $display("FAIL b2b_done_cyc got %0d exp %0d", first_done, last_samp_cyc + 1); end
    endtask

    task automatic test_backpressure();
        run_xfer(15'h0050, 15'd2, 1, -1, 400);
        checks++; if (timeout !== 0) begin failures++; $display("FAIL bp_timeout got %0d exp 0", timeout); end
        checks++; if (n_samp !== 32) begin failures++; $display("FAIL bp_count got %0d exp 32", n_samp); end
        checks++; if (unstable !== 0) begin failures++; $display("FAIL bp_stable got %0d exp 0", unstable); end
        for (int k = 0; k < 32 && k < n_samp; k++) begin
            checks++;
            if (samp[k] !== pat(32'h50 + k / 16, k % 16))
                begin failures++; $display("FAIL bp_sample%0d got %h exp %h", k, samp[k], pat(32'h50 + k / 16, k % 16)); end
        end
    endtask

    task automatic test_wrap();
        run_xfer(15'h7FFF, 15'd2, 0, -1, 200);
        checks++; if (timeout !== 0) begin failures++; $display("FAIL wrap_timeout got %0d exp 0", timeout); end
        checks++; if (n_addr !== 2 || addrs[0] !== 15'h7FFF || addrs[1] !== 15'h0000)
            begin failures++; $display("FAIL wrap_addrs got n%0d %h %h exp 2 7fff 0000", n_addr, addrs[0], addrs[1]); end
        checks++; if (n_samp !== 32) begin failures++; $display("FAIL wrap_count got %0d exp 32", n_samp); end
        for (int k = 0; k < 32 && k < n_samp; k++) begin
            checks++;
            if (samp[k] !== pat((32'h7FFF + k / 16) & 32'h7FFF, k % 16))
                begin failures++; $display("FAIL wrap_sample%0d got %h exp %h", k, samp[k], pat((32'h7FFF + k / 16) & 32'h7FFF, k % 16)); end
        end
    endtask

    task automatic test_empty();
        run_xfer(15'h0010, 15'd0, 0, -1, 20);
        checks++; if (first_done !== 1) begin failures++; $display("FAIL empty_done_cyc got %0d exp 1", first_done); end
        checks++; if (busy_seen !== 1'b0) begin failures++; $display("FAIL empty_busy got %b exp 0", busy_seen); end
        checks++; if (valid_seen !== 1'b0) begin failures++; $display("FAIL empty_valid got %b exp 0", valid_seen); end
    endtask

    task automatic test_abort();
        run_xfer(15'h0040, 15'd4, 0, 5, 100);
        checks++; if (timeout !== 0) begin failures++; $display("FAIL abort_timeout got %0d exp 0", timeout); end
        checks++; if (n_samp !== 5) begin failures++; $display("FAIL abort_count got %0d exp 5", n_samp); end
        checks++; if (valid_after_abort !== 1'b0) begin failures++; $display("FAIL abort_valid got %b exp 0", valid_after_abort); end
        checks++; if (busy_after_abort !== 1'b0) begin failures++; $display("FAIL abort_busy got %b exp 0", busy_after_abort); end
        checks++; if (n_done !== 0) begin failures++; $display("FAIL abort_done got %0d exp 0", n_done); end
        for (int k = 0; k < 5 && k < n_samp; k++) begin
            checks++;
            if (samp[k] !== pat(32'h40, k)) begin failures++; $display("FAIL abort_sample%0d got %h exp %h", k, samp[k], pat(32'h40, k)); end
        end
        run_xfer(15'h0030, 15'd1, 0, -1, 100);
        checks++; if (timeout !== 0) begin failures++; $display("FAIL restart_timeout got %0d exp 0", timeout); end
        checks++; if (n_samp !== 16) begin failures++; $display("FAIL restart_count got %0d exp 16", n_samp); end
        checks++; if (first_valid !== 2) begin failures++; $display("FAIL restart_first_valid got %0d exp 2", first_valid); end
        for (int k = 0; k < 16 && k < n_samp; k++) begin
            checks++;
            if (samp[k] !== pat(32'h30, k)) begin failures++; $display("FAIL restart_sample%0d got %h exp %h", k, samp[k], pat(32'h30, k)); end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_empty();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
